// File: rtl/control_sequencer.sv
// Hardwired control unit: steps each instruction through fetch (T0-T2) and execute (T3-T5),
// driving datapath enables, bus source, memory read and ALU operation from the decoded IR.
module control_sequencer #(
    parameter int unsigned SEL_W = 5,
    parameter int unsigned EN_W  = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [31:0]      ir,
    output logic [EN_W-1:0]  enable,
    output logic [SEL_W-1:0] bus_sel,
    output logic             bus_sel_vld,
    output logic             mr_read,
    output logic             pc_inc,
    output logic [3:0]       alu_op,
    output logic             done,
    output logic             illegal,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StT0   = 3'd1,
        StT1   = 3'd2,
        StT2   = 3'd3,
        StT3   = 3'd4,
        StT4   = 3'd5,
        StT5   = 3'd6,
        StHalt = 3'd7
    } state_t;

    localparam logic [4:0] IdxY   = 5'd19;
    localparam logic [4:0] IdxPc  = 5'd20;
    localparam logic [4:0] IdxMdr = 5'd21;
    localparam logic [4:0] IdxZlo = 5'd22;
    localparam logic [4:0] IdxIr  = 5'd23;
    localparam logic [4:0] IdxZ   = 5'd24;
    localparam logic [4:0] IdxMar = 5'd25;

    state_t state_q, state_d;
    logic   illegal_q;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_3reg, is_unary;
    logic [3:0] unary_alu;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign is_3reg   = (op >= 5'd3) && (op <= 5'd10);
    assign is_unary  = (op == 5'd17) || (op == 5'd18);
    assign unary_alu = (op == 5'd17) ? 4'd11 : 4'd12;

    function automatic logic [EN_W-1:0] en_bit(input logic [4:0] idx);
        logic [EN_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StT3 && !is_3reg && !is_unary) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        enable      = '0;
        bus_sel     = '0;
        bus_sel_vld = 1'b0;
        mr_read     = 1'b0;
        pc_inc      = 1'b0;
        alu_op      = 4'd0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StT0;
            end
            StT0: begin
                bus_sel     = SEL_W'(IdxPc);
                bus_sel_vld = 1'b1;
                enable      = en_bit(IdxMar);
                pc_inc      = 1'b1;
                state_d     = StT1;
            end
            StT1: begin
                mr_read = 1'b1;
                enable  = en_bit(IdxMdr);
                state_d = StT2;
            end
            StT2: begin
                bus_sel     = SEL_W'(IdxMdr);
                bus_sel_vld = 1'b1;
                enable      = en_bit(IdxIr);
                state_d     = StT3;
            end
            StT3: begin
                bus_sel_vld = 1'b1;
                if (is_3reg) begin
                    bus_sel = SEL_W'(rb);
                    enable  = en_bit(IdxY);
                    state_d = StT4;
                end else if (is_unary) begin
                    bus_sel = SEL_W'(rb);
                    alu_op  = unary_alu;
                    enable  = en_bit(IdxZ);
                    state_d = StT5;
                end else begin
                    state_d = StHalt;
                end
            end
            StT4: begin
                bus_sel     = SEL_W'(rc);
                bus_sel_vld = 1'b1;
                alu_op      = op[3:0];
                enable      = en_bit(IdxZ);
                state_d     = StT5;
            end
            StT5: begin
                bus_sel     = SEL_W'(IdxZlo);
                bus_sel_vld = 1'b1;
                enable      = en_bit({1'b0, ra});
                done        = 1'b1;
                state_d     = run ? StT0 : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed instruction sequences plus randomized traffic compared every
// cycle against a model that expands each instruction into its list of expected control steps.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        run = 1'b0;
    logic [31:0] ir  = 32'h0;
    logic [31:0] enable;
    logic [4:0]  bus_sel;
    logic        bus_sel_vld, mr_read, pc_inc, done, illegal;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    control_sequencer #(.SEL_W(5), .EN_W(32)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir),
        .enable(enable), .bus_sel(bus_sel), .bus_sel_vld(bus_sel_vld),
        .mr_read(mr_read), .pc_inc(pc_inc), .alu_op(alu_op), .done(done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] st, en, bs, alu;
        logic        vld, mr, pc, dn, hlt, nobs;
    } exp_t;

    exp_t q[$];
    bit   halted = 1'b0;
    bit   ill_m  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t rec(input int st, input int en, input int bs, input bit vld,
                                 input bit mr, input bit pc, input int alu, input bit dn,
                                 input bit hlt, input bit nobs);
        exp_t r;
        r.st   = 32'(st);
        r.en   = (en < 0) ? 32'h0 : (32'h1 << en);
        r.bs   = 32'(bs);
        r.vld  = vld;
        r.mr   = mr;
        r.pc   = pc;
        r.alu  = 32'(alu);
        r.dn   = dn;
        r.hlt  = hlt;
        r.nobs = nobs;
        return r;
    endfunction

    function automatic exp_t cur();
        if (q.size() != 0) return q[0];
        return rec(halted ? 7 : 0, -1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic push_fetch();
        q.push_back(rec(1, 25, 20, 1, 0, 1, 0, 0, 0, 0));
        q.push_back(rec(2, 21, 0, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(rec(3, 23, 21, 1, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic push_exec(input logic [31:0] v);
        int op, ra, rb, rc;
        op = int'(v[31:27]);
        ra = int'(v[26:23]);
        rb = int'(v[22:19]);
        rc = int'(v[18:15]);
        if (op >= 3 && op <= 10) begin
            q.push_back(rec(4, 19, rb, 1, 0, 0, 0, 0, 0, 0));
            q.push_back(rec(5, 24, rc, 1, 0, 0, op, 0, 0, 0));
            q.push_back(rec(6, ra, 22, 1, 0, 0, 0, 1, 0, 0));
        end else if (op == 17 || op == 18) begin
            q.push_back(rec(4, 24, rb, 1, 0, 0, (op == 17) ? 11 : 12, 0, 0, 0));
            q.push_back(rec(6, ra, 22, 1, 0, 0, 0, 1, 0, 0));
        end else begin
            q.push_back(rec(4, -1, 0, 1, 0, 0, 0, 0, 1, 1));
        end
    endtask

    // Advance the model at a rising edge using the inputs the DUT samples there.
    task automatic model_step();
        exp_t r;
        if (!clr) return;
        if (q.size() == 0) begin
            if (!halted && run) push_fetch();
        end else begin
            r = q.pop_front();
            if (r.hlt) begin
                halted = 1'b1;
                ill_m  = 1'b1;
            end else if (r.st == 32'd3) begin
                push_exec(ir);
            end else if (r.dn && run) begin
                push_fetch();
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        halted = 1'b0;
        ill_m  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = cur();
        chk("state", 32'(state), e.st);
        chk("enable", enable, e.en);
        if (e.vld && !e.nobs) chk("bus_sel", 32'(bus_sel), e.bs);
        chk("bus_sel_vld", 32'(bus_sel_vld), 32'(e.vld));
        chk("mr_read", 32'(mr_read), 32'(e.mr));
        chk("pc_inc", 32'(pc_inc), 32'(e.pc));
        chk("alu_op", 32'(alu_op), e.alu);
        chk("done", 32'(done), 32'(e.dn));
        chk("illegal", 32'(illegal), 32'(ill_m));
        chk("onehot0", 32'($onehot0(enable)), 32'd1);
    end

    function automatic logic [31:0] rand_ir();
        int          legal[10] = '{3, 4, 5, 6, 7, 8, 9, 10, 17, 18};
        int          op;
        logic [31:0] v;
        op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                         : legal[$urandom_range(0, 9)];
        v = $urandom();
        v[31:27] = 5'(op);
        return v;
    endfunction

    task automatic async_reset_pulse();
        #2 clr = 1'b0;
        model_reset();
        #1;
        chk("rst_enable", enable, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        #3 clr = 1'b1;
    endtask

    initial begin
        // Test 1: reset, then idle with run low.
        #1 clr = 1'b0;
        #12 clr = 1'b1;
        repeat (5) begin
            tick();
            chk("t1_state", 32'(state), 32'd0);
            chk("t1_enable", enable, 32'h0);
        end

        // Test 2: not R1,R2 (unary), run dropped after T0.
        ir = 32'h9090_0000;
        run = 1'b1;
        tick();
        chk("t2_t0_state", 32'(state), 32'd1);
        chk("t2_t0_bus", 32'(bus_sel), 32'd20);
        chk("t2_t0_en", enable, 32'h0200_0000);
        chk("t2_t0_pc", 32'(pc_inc), 32'd1);
        run = 1'b0;
        tick();
        chk("t2_t1_mr", 32'(mr_read), 32'd1);
        chk("t2_t1_en", enable, 32'h0020_0000);
        tick();
        chk("t2_t2_bus", 32'(bus_sel), 32'd21);
        chk("t2_t2_en", enable, 32'h0080_0000);
        tick();
        chk("t2_t3_bus", 32'(bus_sel), 32'd2);
        chk("t2_t3_alu", 32'(alu_op), 32'd12);
        chk("t2_t3_en", enable, 32'h0100_0000);
        tick();
        chk("t2_t5_state", 32'(state), 32'd6);
        chk("t2_t5_bus", 32'(bus_sel), 32'd22);
        chk("t2_t5_en", enable, 32'h0000_0002);
        chk("t2_t5_done", 32'(done), 32'd1);
        tick();
        chk("t2_idle", 32'(state), 32'd0);

        // Test 3: or R3,R1,R2 back-to-back.
        ir = 32'h3189_0000;
        run = 1'b1;
        repeat (4) tick();
        chk("t3_t3_bus", 32'(bus_sel), 32'd1);
        chk("t3_t3_en", enable, 32'h0008_0000);
        tick();
        chk("t3_t4_bus", 32'(bus_sel), 32'd2);
        chk("t3_t4_alu", 32'(alu_op), 32'd6);
        chk("t3_t4_en", enable, 32'h0100_0000);
        tick();
        chk("t3_t5_en", enable, 32'h0000_0008);
        chk("t3_t5_done", 32'(done), 32'd1);
        tick();
        chk("t3_next_t0", 32'(state), 32'd1);
        run = 1'b0;
        repeat (5) tick();
        chk("t3_second_t5", 32'(state), 32'd6);
        tick();
        chk("t3_idle", 32'(state), 32'd0);

        // Test 4: undefined opcode halts until reset.
        ir = 32'hF800_0000;
        run = 1'b1;
        repeat (4) tick();
        chk("t4_t3_state", 32'(state), 32'd4);
        chk("t4_t3_en", enable, 32'h0);
        tick();
        chk("t4_halt_state", 32'(state), 32'd7);
        repeat (20) begin
            tick();
            chk("t4_hold_ill", 32'(illegal), 32'd1);
            chk("t4_hold_state", 32'(state), 32'd7);
        end
        run = 1'b0;
        async_reset_pulse();

        // Test 5: reset asserted between edges during T4.
        ir = 32'h3189_0000;
        run = 1'b1;
        tick();
        repeat (4) tick();
        chk("t5_in_t4", 32'(state), 32'd5);
        async_reset_pulse();
        tick();
        chk("t5_restart", 32'(state), 32'd1);
        run = 1'b0;
        repeat (6) tick();
        chk("t5_idle", 32'(state), 32'd0);

        // Randomized traffic; ir only changes where the sequencer does not read it.
        repeat (700) begin
            tick();
            if ((halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 79) == 0) begin
                async_reset_pulse();
            end else begin
                run = ($urandom_range(0, 3) != 0);
                if (q.size() == 0 || q[0].st <= 32'd3) ir = rand_ir();
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
